// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch-op encodings, fetch FSM states, reset PC.
// Imported by the fetch unit, the branch resolver and the decoder.
package cpu_pkg;

  localparam logic [2:0] BR_OP_BR   = 3'b000;
  localparam logic [2:0] BR_OP_BMI  = 3'b001;
  localparam logic [2:0] BR_OP_BPL  = 3'b010;
  localparam logic [2:0] BR_OP_BZ   = 3'b011;
  localparam logic [2:0] BR_OP_NONE = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HALTED
  } ifu_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0;

endpackage

// File: rtl/branch_resolver.sv
// Next-PC computation: pc+4, or pc+4+sext(offset)<<2 when the branch is taken.
// Ports: pc, instr, br_op, imm_sel, rs_val in; next_pc, taken out. ADDR_W > 28.
module branch_resolver
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] instr,
  input  logic [2:0]        br_op,
  input  logic              imm_sel,
  input  logic [DATA_W-1:0] rs_val,
  output logic [ADDR_W-1:0] next_pc,
  output logic              taken
);

  logic [25:0]       imm;
  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] seq;
  logic              rs_neg;
  logic              rs_zero;
  logic              unused_hi;

  assign unused_hi = ^instr[DATA_W-1:26];
  assign rs_neg    = rs_val[DATA_W-1];
  assign rs_zero   = (rs_val == '0);

  always_comb begin
    imm = imm_sel ? instr[25:0]
                  : {{10{instr[15]}}, instr[15:0]};
    off = {{(ADDR_W-28){imm[25]}}, imm, 2'b00};
    seq = pc + ADDR_W'(4);
    taken = 1'b0;
    unique case (1'b1)
      (br_op == BR_OP_BR):  taken = 1'b1;
      (br_op == BR_OP_BMI): taken = rs_neg;
      (br_op == BR_OP_BPL): taken = !rs_neg && !rs_zero;
      (br_op == BR_OP_BZ):  taken = rs_zero;
      default:              taken = 1'b0;
    endcase
    next_pc = taken ? seq + off : seq;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch/PC stage: req/ack instruction fetch, issue hold, next-PC select, halt.
// Ports: start, imem_* handshake, instr/instr_valid, exec_done + branch ctrl, pc, halted, retired.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int               ADDR_W   = 32,
  parameter int               DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_ack,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              exec_done,
  input  logic              upd_pc,
  input  logic [2:0]        br_op,
  input  logic              imm_sel,
  input  logic [DATA_W-1:0] rs_val,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [31:0]       retired
);

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [31:0]       retired_q, retired_d;
  logic [ADDR_W-1:0] br_next;
  logic              unused_taken;

  branch_resolver #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_br (
    .pc      (pc_q),
    .instr   (instr_q),
    .br_op   (br_op),
    .imm_sel (imm_sel),
    .rs_val  (rs_val),
    .next_pc (br_next),
    .taken   (unused_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (exec_done) begin
          retired_d = retired_q + 32'd1;
          if (!upd_pc) begin
            state_d = S_HALTED;
          end else begin
            pc_d    = br_next;
            state_d = S_FETCH;
          end
        end
      end
      S_HALTED: ;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode straight from state so reset drops the request at once.
  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == S_ISSUE);
  assign halted      = (state_q == S_HALTED);
  assign pc          = pc_q;
  assign retired     = retired_q;

endmodule
